// File: rtl/out_drain_if.sv
// out_drain_if: PE-array result stream into the drain block and the output-SRAM write port out of it.
// A beat (ACC_VALID_in/ACC_READY_out) or a write (SRAM_WEN_out/SRAM_WREADY_in) transfers on a rising edge where its valid and ready are both high; valid never depends on ready.
interface out_drain_if #(
  parameter int ACC_BWIDTH        = 32,
  parameter int PE_ARRAY_NUM_COLS = 4,
  parameter int OUT_SRAM_AWIDTH   = 10
);
  logic                                      ACC_VALID_in;
  logic [PE_ARRAY_NUM_COLS*ACC_BWIDTH-1:0]   ACC_DATA_in;
  logic                                      ACC_READY_out;
  logic                                      SRAM_WEN_out;
  logic [OUT_SRAM_AWIDTH-1:0]                SRAM_WADDR_out;
  logic [PE_ARRAY_NUM_COLS*ACC_BWIDTH-1:0]   SRAM_WDATA_out;
  logic                                      SRAM_WREADY_in;

  modport slave (
    input  ACC_VALID_in, ACC_DATA_in, SRAM_WREADY_in,
    output ACC_READY_out, SRAM_WEN_out, SRAM_WADDR_out, SRAM_WDATA_out
  );

  modport master (
    output ACC_VALID_in, ACC_DATA_in, SRAM_WREADY_in,
    input  ACC_READY_out, SRAM_WEN_out, SRAM_WADDR_out, SRAM_WDATA_out
  );
endinterface

// File: rtl/out_drain.sv
// out_drain: buffers PE-array result beats in a 2-entry FIFO, masks lanes past N and writes them to sequential SRAM addresses.
// Optional macro OUT_DRAIN_RELU_EN clamps negative valid lanes to zero before the write.
module out_drain #(
  parameter int ACC_BWIDTH             = 32,
  parameter int PE_ARRAY_NUM_COLS      = 4,
  parameter int PE_ARRAY_NUM_COLS_LOG2 = 2,
  parameter int MAX_M_SIZE_LOG2        = 9,
  parameter int MAX_N_SIZE_LOG2        = 9,
  parameter int OUT_SRAM_AWIDTH        = 10
) (
  input  logic                       CLK,
  input  logic                       RSTn,
  input  logic                       START,
  input  logic                       STALL,
  input  logic [MAX_M_SIZE_LOG2-1:0] M_SIZE_in,
  input  logic [MAX_N_SIZE_LOG2-1:0] N_SIZE_in,
  out_drain_if.slave                 bus,
  output logic                       BUSY_out,
  output logic                       IS_FINISHED_out,
  output logic [1:0]                 STATE_dbg_out
);
  localparam int CW = MAX_M_SIZE_LOG2 + MAX_N_SIZE_LOG2;
  localparam int NC = PE_ARRAY_NUM_COLS;
  localparam int DW = NC * ACC_BWIDTH;
  localparam int MW = MAX_M_SIZE_LOG2;
  localparam int NW = MAX_N_SIZE_LOG2;
  localparam int AW = OUT_SRAM_AWIDTH;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_DRAIN = 2'd1, S_DONE = 2'd2} state_t;

  state_t          state_q, state_d;
  logic [MW-1:0]   m_q, m_d;
  logic [NW-1:0]   n_q, n_d;
  logic [CW-1:0]   total_q, total_d;
  logic [CW-1:0]   acc_cnt_q, acc_cnt_d;
  logic [CW-1:0]   wr_cnt_q, wr_cnt_d;
  logic [MW-1:0]   in_row_q, in_row_d;
  logic [CW-1:0]   col_base_q, col_base_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   fifo_data_q [2];
  logic [DW-1:0]   fifo_data_d [2];
  logic [NC-1:0]   fifo_mask_q [2];
  logic [NC-1:0]   fifo_mask_d [2];
  logic            wr_ptr_q, wr_ptr_d;
  logic            rd_ptr_q, rd_ptr_d;
  logic [1:0]      count_q, count_d;

  logic            fifo_full, fifo_nempty;
  logic            acc_ready, push, wen, pop;
  logic            start_job;
  logic [CW-1:0]   ct_in;
  logic [NC-1:0]   push_mask;
  logic [DW-1:0]   head_data;
  logic [ACC_BWIDTH-1:0] lane;

  assign fifo_full   = (count_q == 2'd2);
  assign fifo_nempty = (count_q != 2'd0);
  assign acc_ready   = (state_q == S_DRAIN) && !fifo_full && (acc_cnt_q < total_q);
  assign push        = bus.ACC_VALID_in && acc_ready;
  assign wen         = fifo_nempty && !STALL;
  assign pop         = wen && bus.SRAM_WREADY_in;
  assign start_job   = (state_q == S_IDLE) && START;
  assign ct_in       = (CW'(N_SIZE_in) + CW'(NC - 1)) >> PE_ARRAY_NUM_COLS_LOG2;

  // Lane j of the beat being accepted is live while its absolute column is below N.
  always_comb begin
    push_mask = '0;
    for (int j = 0; j < NC; j++) begin
      push_mask[j] = (col_base_q + CW'(j)) < CW'(n_q);
    end
  end

  always_comb begin
    head_data = '0;
    lane      = '0;
    for (int j = 0; j < NC; j++) begin
      lane = fifo_data_q[rd_ptr_q][j*ACC_BWIDTH +: ACC_BWIDTH];
      if (!fifo_mask_q[rd_ptr_q][j]) lane = '0;
`ifdef OUT_DRAIN_RELU_EN
      if (lane[ACC_BWIDTH-1]) lane = '0;
`else
`endif
      head_data[j*ACC_BWIDTH +: ACC_BWIDTH] = lane;
    end
  end

  assign bus.ACC_READY_out  = acc_ready;
  assign bus.SRAM_WEN_out   = wen;
  assign bus.SRAM_WADDR_out = addr_q;
  assign bus.SRAM_WDATA_out = fifo_nempty ? head_data : '0;
  assign STATE_dbg_out      = state_q;

  // State register plus all datapath flops.
  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      state_q    <= S_IDLE;
      m_q        <= '0;
      n_q        <= '0;
      total_q    <= '0;
      acc_cnt_q  <= '0;
      wr_cnt_q   <= '0;
      in_row_q   <= '0;
      col_base_q <= '0;
      addr_q     <= '0;
      for (int i = 0; i < 2; i++) begin
        fifo_data_q[i] <= '0;
        fifo_mask_q[i] <= '0;
      end
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      count_q    <= 2'd0;
    end else begin
      state_q    <= state_d;
      m_q        <= m_d;
      n_q        <= n_d;
      total_q    <= total_d;
      acc_cnt_q  <= acc_cnt_d;
      wr_cnt_q   <= wr_cnt_d;
      in_row_q   <= in_row_d;
      col_base_q <= col_base_d;
      addr_q     <= addr_d;
      for (int i = 0; i < 2; i++) begin
        fifo_data_q[i] <= fifo_data_d[i];
        fifo_mask_q[i] <= fifo_mask_d[i];
      end
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (START) begin
          if (M_SIZE_in == '0 || N_SIZE_in == '0) state_d = S_DONE;
          else                                     state_d = S_DRAIN;
        end
      end
      S_DRAIN: if (pop && (wr_cnt_q + CW'(1) == total_q)) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    BUSY_out        = 1'b0;
    IS_FINISHED_out = 1'b0;
    case (state_q)
      S_DRAIN: BUSY_out        = 1'b1;
      S_DONE:  IS_FINISHED_out = 1'b1;
      default: ;
    endcase
  end

  // Push and pop never coincide with a job start: both need DRAIN or a non-empty FIFO.
  always_comb begin
    m_d         = m_q;
    n_d         = n_q;
    total_d     = total_q;
    acc_cnt_d   = acc_cnt_q;
    wr_cnt_d    = wr_cnt_q;
    in_row_d    = in_row_q;
    col_base_d  = col_base_q;
    addr_d      = addr_q;
    fifo_data_d = fifo_data_q;
    fifo_mask_d = fifo_mask_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;

    if (start_job) begin
      m_d        = M_SIZE_in;
      n_d        = N_SIZE_in;
      total_d    = CW'(M_SIZE_in) * ct_in;
      acc_cnt_d  = '0;
      wr_cnt_d   = '0;
      in_row_d   = '0;
      col_base_d = '0;
      addr_d     = '0;
      wr_ptr_d   = 1'b0;
      rd_ptr_d   = 1'b0;
      count_d    = 2'd0;
    end

    if (push) begin
      fifo_data_d[wr_ptr_q] = bus.ACC_DATA_in;
      fifo_mask_d[wr_ptr_q] = push_mask;
      wr_ptr_d              = ~wr_ptr_q;
      acc_cnt_d             = acc_cnt_q + CW'(1);
      if (in_row_q == m_q - MW'(1)) begin
        in_row_d   = '0;
        col_base_d = col_base_q + CW'(NC);
      end else begin
        in_row_d   = in_row_q + MW'(1);
      end
    end

    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
      wr_cnt_d = wr_cnt_q + CW'(1);
      addr_d   = addr_q + AW'(1);
    end

    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: ;
    endcase
  end
endmodule

// File: tb/tb_out_drain.sv
// tb_out_drain: directed jobs against a beat-order/mask/address model; a negedge compare process checks every SRAM write and done pulse.
`timescale 1ns/1ps
module tb_out_drain;
  localparam int B  = 32;
  localparam int C  = 4;
  localparam int MW = 9;
  localparam int NW = 9;
  localparam int AW = 10;
  localparam int DW = C * B;

  // clock / reset
  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  logic          start = 1'b0;
  logic          stall = 1'b0;
  logic [MW-1:0] m_in = '0;
  logic [NW-1:0] n_in = '0;
  logic          busy, fin;
  logic [1:0]    dbg_state;

  out_drain_if #(.ACC_BWIDTH(B), .PE_ARRAY_NUM_COLS(C), .OUT_SRAM_AWIDTH(AW)) bus ();

  out_drain #(
    .ACC_BWIDTH(B), .PE_ARRAY_NUM_COLS(C), .PE_ARRAY_NUM_COLS_LOG2(2),
    .MAX_M_SIZE_LOG2(MW), .MAX_N_SIZE_LOG2(NW), .OUT_SRAM_AWIDTH(AW)
  ) dut (
    .CLK(clk), .RSTn(rstn), .START(start), .STALL(stall),
    .M_SIZE_in(m_in), .N_SIZE_in(n_in), .bus(bus.slave),
    .BUSY_out(busy), .IS_FINISHED_out(fin), .STATE_dbg_out(dbg_state)
  );

  // scoreboard state
  logic [DW-1:0] exp_q[$];
  logic [AW-1:0] exp_addr_q[$];
  logic [DW-1:0] got_data_q[$];
  logic [AW-1:0] got_addr_q[$];
  logic [DW-1:0] src_q[$];
  int checks = 0, errors = 0, fin_cnt = 0, acc_cnt = 0;
  bit rnd_en = 1'b0;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Model: beat b belongs to column tile b/M; lane j lives iff tile*C+j < N; write b lands at b mod 2^AW.
  function automatic logic [DW-1:0] model_beat(input logic [DW-1:0] d, input int ct, input int n);
    logic [DW-1:0] r;
    logic [B-1:0]  l;
    r = '0;
    for (int j = 0; j < C; j++) begin
      l = d[j*B +: B];
      if (ct*C + j >= n) l = '0;
`ifdef OUT_DRAIN_RELU_EN
      if (l[B-1]) l = '0;
`endif
      r[j*B +: B] = l;
    end
    return r;
  endfunction

  task automatic expect_job(input int m, input int n);
    for (int b = 0; b < src_q.size(); b++) begin
      exp_q.push_back(model_beat(src_q[b], b / m, n));
      exp_addr_q.push_back(AW'(b % (1 << AW)));
    end
  endtask

  // compare process
  always @(negedge clk) begin
    if (rstn) begin
      if (stall) check("stall_blocks_wen", DW'(bus.SRAM_WEN_out), '0);
      if (bus.SRAM_WEN_out && bus.SRAM_WREADY_in) begin
        got_data_q.push_back(bus.SRAM_WDATA_out);
        got_addr_q.push_back(bus.SRAM_WADDR_out);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write got addr %0d expected no write", bus.SRAM_WADDR_out);
        end else begin
          check("wdata", bus.SRAM_WDATA_out, exp_q.pop_front());
          check("waddr", DW'(bus.SRAM_WADDR_out), DW'(exp_addr_q.pop_front()));
        end
      end
      if (fin) begin
        fin_cnt++;
        check("fin_after_last_write", DW'(exp_q.size()), '0);
      end
    end
  end

  // background random stall / write-ready
  initial begin
    forever begin
      tick();
      if (rnd_en) begin
        stall             = ($urandom_range(0, 3) == 0);
        bus.SRAM_WREADY_in = ($urandom_range(0, 2) != 0);
      end
    end
  end

  // driver tasks
  task automatic drive_beats(input int k);
    int i = 0;
    int guard = 0;
    while (i < k && guard < k*20 + 100) begin
      tick();
      bus.ACC_VALID_in = 1'b1;
      bus.ACC_DATA_in  = src_q[i];
      if (bus.ACC_READY_out) begin
        i++;
        acc_cnt++;
      end
      guard++;
    end
    tick();
    bus.ACC_VALID_in = 1'b0;
    if (i < k) begin
      checks++;
      errors++;
      $display("FAIL beat_timeout got %0d beats expected %0d", i, k);
    end
  endtask

  task automatic start_job(input int m, input int n);
    tick();
    m_in  = MW'(m);
    n_in  = NW'(n);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic run_job(input string name, input int m, input int n);
    int f0;
    int guard;
    exp_q.delete();
    exp_addr_q.delete();
    got_data_q.delete();
    got_addr_q.delete();
    acc_cnt = 0;
    expect_job(m, n);
    f0 = fin_cnt;
    start_job(m, n);
    drive_beats(src_q.size());
    guard = 0;
    while (fin_cnt == f0 && guard < 500) begin
      tick();
      guard++;
    end
    tick();
    tick();
    check({name, "_one_fin_pulse"}, DW'(fin_cnt - f0), DW'(1));
    check({name, "_all_written"}, DW'(got_data_q.size()), DW'(src_q.size()));
  endtask

  initial begin
    bus.ACC_VALID_in   = 1'b0;
    bus.ACC_DATA_in    = '0;
    bus.SRAM_WREADY_in = 1'b1;
    repeat (3) tick();
    check("rst_ready", DW'(bus.ACC_READY_out), '0);
    check("rst_wen", DW'(bus.SRAM_WEN_out), '0);
    check("rst_waddr", DW'(bus.SRAM_WADDR_out), '0);
    check("rst_wdata", bus.SRAM_WDATA_out, '0);
    check("rst_busy_fin", DW'({busy, fin}), '0);
    rstn = 1'b1;
    tick();

    // basic two-row job
    src_q = '{128'h0DDC0FFE_0BADF00D_12345678_3AFEBABE, 128'h01020304_05060708_090A0B0C_0D0E0F10};
    run_job("t1", 2, 4);
    check("t1_w0_data", got_data_q[0], 128'h0DDC0FFE_0BADF00D_12345678_3AFEBABE);
    check("t1_w1_addr", DW'(got_addr_q[1]), DW'(1));

    // partial last tile
    src_q = '{128'h88888888_77777777_66666666_55555555, 128'h44444444_33333333_22222222_11111111};
    run_job("t2", 1, 6);
    check("t2_w1_masked", got_data_q[1], 128'h00000000_00000000_22222222_11111111);

    // write back-pressure fills the FIFO
    src_q = '{128'h1, 128'h2, 128'h3, 128'h4};
    bus.SRAM_WREADY_in = 1'b0;
    fork
      run_job("t3", 4, 4);
      begin
        repeat (8) tick();
        check("t3_accepted_before_full", DW'(acc_cnt), DW'(2));
        check("t3_ready_low_when_full", DW'(bus.ACC_READY_out), '0);
        bus.SRAM_WREADY_in = 1'b1;
      end
    join
    for (int i = 0; i < 4; i++) check("t3_addr_order", DW'(got_addr_q[i]), DW'(i));

    // empty job finishes one cycle after the start edge
    got_data_q.delete();
    begin
      int f0;
      f0 = fin_cnt;
      start_job(0, 8);
      check("t4_fin_high", DW'(fin), DW'(1));
      tick();
      check("t4_fin_low", DW'(fin), '0);
      tick();
      check("t4_fin_count", DW'(fin_cnt - f0), DW'(1));
      check("t4_no_writes", DW'(got_data_q.size()), '0);
    end

    // negative lane handling
    src_q = '{{32'h00000001, 32'h80000000, 32'h7FFFFFFF, 32'hFFFFFFFF}};
    run_job("t5", 1, 4);
`ifdef OUT_DRAIN_RELU_EN
    check("t5_relu", got_data_q[0], {32'h00000001, 32'h00000000, 32'h7FFFFFFF, 32'h00000000});
`else
    check("t5_passthru", got_data_q[0], {32'h00000001, 32'h80000000, 32'h7FFFFFFF, 32'hFFFFFFFF});
`endif

    // random stall and write-ready, three tiles with a partial last tile
    src_q.delete();
    for (int i = 0; i < 9; i++) src_q.push_back({$urandom, $urandom, $urandom, $urandom});
    rnd_en = 1'b1;
    run_job("t6", 3, 9);
    rnd_en = 1'b0;
    tick();
    stall = 1'b0;
    bus.SRAM_WREADY_in = 1'b1;

    // address wrap past 2^AW writes
    src_q.delete();
    for (int i = 0; i < 1028; i++) src_q.push_back({$urandom, $urandom, $urandom, $urandom});
    run_job("t7", 257, 16);
    check("t7_wrap_addr0", DW'(got_addr_q[1024]), '0);
    check("t7_wrap_addr3", DW'(got_addr_q[1027]), DW'(3));

    // reset mid-drain after one of four writes
    src_q = '{128'hA1, 128'hA2, 128'hA3, 128'hA4};
    exp_q.delete();
    exp_addr_q.delete();
    got_data_q.delete();
    got_addr_q.delete();
    expect_job(4, 4);
    stall = 1'b1;
    start_job(4, 4);
    drive_beats(2);
    stall = 1'b0;
    tick();
    stall = 1'b1;
    rstn = 1'b0;
    tick();
    check("t8_one_write_before_rst", DW'(got_data_q.size()), DW'(1));
    check("t8_rst_wen", DW'(bus.SRAM_WEN_out), '0);
    check("t8_rst_busy", DW'(busy), '0);
    check("t8_rst_waddr", DW'(bus.SRAM_WADDR_out), '0);
    rstn = 1'b1;
    stall = 1'b0;
    tick();
    src_q = '{128'hB1};
    run_job("t8", 1, 4);
    check("t8_restart_addr", DW'(got_addr_q[0]), '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/out_drain.md
OUT_DRAIN -- requirements
Module: out_drain

Interface
REQ-001 SHALL have parameter ACC_BWIDTH, default 32, the accumulator lane width in bits.
REQ-002 SHALL have parameter PE_ARRAY_NUM_COLS, default 4, the lanes per beat; PE_ARRAY_NUM_COLS_LOG2, default 2.
REQ-003 SHALL have parameters MAX_M_SIZE_LOG2, default 9, and MAX_N_SIZE_LOG2, default 9, the matrix size field widths.
REQ-004 SHALL have parameter OUT_SRAM_AWIDTH, default 10, the output SRAM address width.
REQ-005 SHALL have port CLK  in  1  clock; all logic is on the rising edge.
REQ-006 SHALL have port RSTn  in  1  reset, synchronous, active-low.
REQ-007 SHALL have port START  in  1  begins a drain job (sampled in IDLE only).
REQ-008 SHALL have port STALL  in  1  while high, suppresses SRAM writes.
REQ-009 SHALL have ports M_SIZE_in  in  MAX_M_SIZE_LOG2 and N_SIZE_in  in  MAX_N_SIZE_LOG2, the result rows and columns.
REQ-010 SHALL have ports ACC_VALID_in  in  1, ACC_DATA_in  in  PE_ARRAY_NUM_COLS*ACC_BWIDTH, and ACC_READY_out  out  1, carrying the PE-array result beats; lane j occupies bits [j*ACC_BWIDTH +: ACC_BWIDTH].
REQ-011 SHALL have ports SRAM_WEN_out  out  1, SRAM_WADDR_out  out  OUT_SRAM_AWIDTH, SRAM_WDATA_out  out  PE_ARRAY_NUM_COLS*ACC_BWIDTH, and SRAM_WREADY_in  in  1, forming the output SRAM write port.
REQ-012 SHALL have ports BUSY_out  out  1 (high in DRAIN) and IS_FINISHED_out  out  1 (one-cycle done pulse).

Function
REQ-013 SHALL implement FSM IDLE -> DRAIN -> DONE -> IDLE.
REQ-014 In IDLE with START=1, SHALL latch M and N, clear the counters and the address, and compute CT=ceil(N/PE_ARRAY_NUM_COLS) and TOTAL=M*CT.
REQ-015 If M=0 or N=0 at START, SHALL go IDLE->DONE directly.
REQ-016 START outside IDLE SHALL be ignored.
REQ-017 An input beat is accepted on an edge where ACC_VALID_in and ACC_READY_out are both high; it is pushed into a 2-entry FIFO.
REQ-018 ACC_READY_out SHALL be registered-state-derived: high only when state is DRAIN, the FIFO is not full, and accepted<TOTAL; a full FIFO blocks the push even if a pop occurs in the same cycle.
REQ-019 Beat order SHALL be column-tile major: for ct in 0..CT-1, for row r in 0..M-1.
REQ-020 Lane j of a beat in tile ct is valid iff ct*PE_ARRAY_NUM_COLS+j<N; invalid lanes SHALL be written as zero.
REQ-021 SRAM_WEN_out SHALL equal (FIFO not empty) and !STALL, with SRAM_WDATA_out taken from the masked FIFO head; a write completes on an edge where SRAM_WEN_out and SRAM_WREADY_in are both high, popping the FIFO.
REQ-022 Latency SHALL be: a beat accepted at edge t is presented no earlier than the cycle following t.
REQ-023 SRAM_WADDR_out SHALL start at 0 per job, increment by 1 per completed write, and wrap modulo 2^OUT_SRAM_AWIDTH.
REQ-024 DRAIN->DONE SHALL occur on the edge that completes write number TOTAL.
REQ-025 In DONE, IS_FINISHED_out=1 for exactly one cycle, then the FSM returns to IDLE.
REQ-026 Arithmetic SHALL use MAX_M_SIZE_LOG2+MAX_N_SIZE_LOG2-bit counters for TOTAL, accepted and written, with no overflow at maximum sizes.

Reset
REQ-027 With RSTn=0 at an edge, SHALL set state=IDLE, FIFO empty, counters and address zero.
REQ-028 With RSTn=0 at an edge, SHALL drive ACC_READY_out, SRAM_WEN_out, BUSY_out and IS_FINISHED_out to 0, and SRAM_WADDR_out and SRAM_WDATA_out to 0.
REQ-029 Reset mid-DRAIN SHALL discard all FIFO contents with no further writes.

Configuration
REQ-030 With macro OUT_DRAIN_RELU_EN defined, each valid lane SHALL be treated as two's-complement and written as 0 if negative, applied after masking.
REQ-031 Without OUT_DRAIN_RELU_EN, lanes SHALL pass through unchanged.

Verification
REQ-032 M=2, N=4, two beats, WREADY=1 -> writes at addresses 0 and 1 with unmodified data, followed by a single IS_FINISHED pulse.
REQ-033 M=1, N=6 -> CT=2, two beats; the second write has lanes 2 and 3 = 0 and lanes 0 and 1 intact.
REQ-034 M=4, N=4, WREADY=0 for 6 cycles -> ACC_READY drops after 2 accepted beats, all 4 writes land in order at 0..3, nothing lost or duplicated.
REQ-035 M=0, N=8 with START -> IS_FINISHED is high exactly one cycle after the start edge, with no SRAM writes.
REQ-036 Lane value 0xFFFFFFFF -> written as 0x00000000 with OUT_DRAIN_RELU_EN and as 0xFFFFFFFF without it.
REQ-037 RSTn low after 1 of 4 writes -> IDLE, WEN=0, and a new START with M=1, N=4 writes at address 0.
